// File: rtl/hwce_wmem_bank_responder.sv
// Bank-side responder for one HWCE weight-memory bank: local word storage behind a
// TCDM-style port, with a clear sequencer, configurable read latency and access counters.
module hwce_wmem_bank_responder #(
    parameter int unsigned BANK_SIZE    = 1024,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned BE_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] add,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BE_WIDTH-1:0]   be,
    output logic                  gnt,
    output logic                  r_valid,
    output logic [DATA_WIDTH-1:0] r_rdata,
    input  logic                  clear_i,
    output logic                  busy_o,
    output logic                  err_o,
    input  logic                  err_clr_i,
    output logic [CNT_WIDTH-1:0]  rd_cnt_o,
    output logic [CNT_WIDTH-1:0]  wr_cnt_o
);

    localparam int unsigned IDX_W = $clog2(BANK_SIZE);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]      clr_idx;
    logic [IDX_W-1:0]      idx;
    logic                  oor;
    logic                  acc;
    logic [DATA_WIDTH-1:0] mem [BANK_SIZE];
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    assign idx     = add[IDX_W-1:0];
    assign oor     = |(add >> IDX_W);
    assign acc     = gnt;
    assign rd_word = oor ? '0 : mem[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_CLEAR;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: if (clr_idx == IDX_W'(BANK_SIZE - 1)) state_next = ST_IDLE;
            ST_IDLE:  if (clear_i) state_next = ST_CLEAR;
            default:  state_next = ST_CLEAR;
        endcase
    end

    always_comb begin
        busy_o = (state == ST_CLEAR);
        gnt    = req & ~busy_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      clr_idx <= '0;
        else if (busy_o) clr_idx <= clr_idx + 1'b1;
        else             clr_idx <= '0;
    end

    always_ff @(posedge clk) begin
        if (busy_o) begin
            mem[clr_idx] <= '0;
        end else if (acc && !wen && !oor) begin
            for (int unsigned i = 0; i < BE_WIDTH; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // s1_data only changes on loads, so it always holds the most recent load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= acc;
            if (acc && wen) s1_data <= rd_word;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            // Delaying s1_data unconditionally still only changes r_rdata with a load response.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_rdata <= '0;
                end else begin
                    r_valid <= s1_valid;
                    r_rdata <= s1_data;
                end
            end
        end else begin : g_lat1
            assign r_valid = s1_valid;
            assign r_rdata = s1_data;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              err_o <= 1'b0;
        else if (acc && oor)     err_o <= 1'b1;
        else if (err_clr_i)      err_o <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else if (acc) begin
            if (wen) rd_cnt_o <= rd_cnt_o + 1'b1;
            else     wr_cnt_o <= wr_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_hwce_wmem_bank_responder.sv
// Self-checking bench for hwce_wmem_bank_responder: latency-1 and latency-2 instances
// share stimulus and are compared every cycle against a queue-based reference model.
module tb_hwce_wmem_bank_responder;

    localparam int unsigned BS = 1024;

    logic        clk = 1'b0;
    logic        rst_n, req, wen, clear_i, err_clr_i;
    logic [31:0] add;
    logic [63:0] wdata;
    logic [7:0]  be;

    logic        gnt1, rv1, busy1, err1;
    logic [63:0] rd1;
    logic [31:0] rc1, wc1;
    logic        gnt2, rv2, busy2, err2;
    logic [63:0] rd2;
    logic [31:0] rc2, wc2;

    always #5 clk = ~clk;

    hwce_wmem_bank_responder #(.BANK_SIZE(BS), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .add(add), .wen(wen), .wdata(wdata), .be(be),
        .gnt(gnt1), .r_valid(rv1), .r_rdata(rd1), .clear_i(clear_i), .busy_o(busy1),
        .err_o(err1), .err_clr_i(err_clr_i), .rd_cnt_o(rc1), .wr_cnt_o(wc1)
    );

    hwce_wmem_bank_responder #(.BANK_SIZE(BS), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .add(add), .wen(wen), .wdata(wdata), .be(be),
        .gnt(gnt2), .r_valid(rv2), .r_rdata(rd2), .clear_i(clear_i), .busy_o(busy2),
        .err_o(err2), .err_clr_i(err_clr_i), .rd_cnt_o(rc2), .wr_cnt_o(wc2)
    );

    typedef struct {
        int unsigned due;
        bit          load;
        logic [63:0] data;
    } resp_t;

    typedef struct {
        bit          req;
        bit          wen;
        logic [31:0] add;
        logic [63:0] data;
        logic [7:0]  be;
        bit          clr;
        bit          eclr;
    } op_t;

    // Reference model state
    logic [63:0] mmem [BS];
    resp_t       q1[$], q2[$];
    int unsigned cyc, busy_left;
    logic        m_err, e_v1, e_v2;
    logic [31:0] m_rc, m_wc;
    logic [63:0] e_d1, e_d2;

    int checks, errors;

    task automatic model_reset();
        q1.delete();
        q2.delete();
        for (int i = 0; i < BS; i++) mmem[i] = '0;
        busy_left = BS;
        m_err = 1'b0;
        m_rc  = '0;
        m_wc  = '0;
        e_v1  = 1'b0;
        e_v2  = 1'b0;
        e_d1  = '0;
        e_d2  = '0;
    endtask

    task automatic step();
        resp_t r;
        bit    acc, oor;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            acc = req && (busy_left == 0);
            oor = (add >= BS);
            if (acc) begin
                r.load = wen;
                r.data = '0;
                if (wen) begin
                    if (!oor) r.data = mmem[add[9:0]];
                    m_rc++;
                end else begin
                    if (!oor)
                        for (int i = 0; i < 8; i++)
                            if (be[i]) mmem[add[9:0]][8*i +: 8] = wdata[8*i +: 8];
                    m_wc++;
                end
                r.due = cyc + 1;
                q1.push_back(r);
                r.due = cyc + 2;
                q2.push_back(r);
            end
            if (acc && oor)     m_err = 1'b1;
            else if (err_clr_i) m_err = 1'b0;
            if (busy_left > 0) busy_left--;
            else if (clear_i) begin
                busy_left = BS;
                for (int i = 0; i < BS; i++) mmem[i] = '0;
            end
        end
        cyc++;
        e_v1 = 1'b0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            r = q1.pop_front();
            e_v1 = 1'b1;
            if (r.load) e_d1 = r.data;
        end
        e_v2 = 1'b0;
        if (q2.size() > 0 && q2[0].due == cyc) begin
            r = q2.pop_front();
            e_v2 = 1'b1;
            if (r.load) e_d2 = r.data;
        end
        #1;
    endtask

    function automatic logic [131:0] act1();
        return {gnt1, rv1, rd1, busy1, err1, rc1, wc1};
    endfunction

    function automatic logic [131:0] act2();
        return {gnt2, rv2, rd2, busy2, err2, rc2, wc2};
    endfunction

    function automatic logic [131:0] exp1();
        return {req && (busy_left == 0), e_v1, e_d1, busy_left != 0, m_err, m_rc, m_wc};
    endfunction

    function automatic logic [131:0] exp2();
        return {req && (busy_left == 0), e_v2, e_d2, busy_left != 0, m_err, m_rc, m_wc};
    endfunction

    function automatic op_t mk(bit r, bit w, logic [31:0] a, logic [63:0] d, logic [7:0] b,
                               bit c, bit e);
        op_t o;
        o.req = r; o.wen = w; o.add = a; o.data = d; o.be = b; o.clr = c; o.eclr = e;
        return o;
    endfunction

    task automatic apply(input op_t o);
        req = o.req; wen = o.wen; add = o.add; wdata = o.data; be = o.be;
        clear_i = o.clr; err_clr_i = o.eclr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        apply(mk(0, 1, 0, 0, 0, 0, 0));
        model_reset();
        #1;
        if (act1() !== exp1()) begin
            errors++;
            $display("FAIL reset_values L1 got %h exp %h", act1(), exp1());
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(1, 1, 5, 0, 0, 0, 0));
        for (int k = 0; k <= BS; k++) begin
            step();
            if (act1() !== exp1()) begin
                errors++;
                $display("FAIL post_reset_clear L1 cyc=%0d got %h exp %h", cyc, act1(), exp1());
            end
            if (act2() !== exp2()) begin
                errors++;
                $display("FAIL post_reset_clear L2 cyc=%0d got %h exp %h", cyc, act2(), exp2());
            end
            checks += 2;
            if (k == BS - 1) begin
                if (gnt1 !== 1'b1) begin
                    errors++;
                    $display("FAIL gnt_after_clear got %b exp 1", gnt1);
                end
                checks++;
                apply(mk(1, 1, 5, 0, 0, 0, 0));
            end
        end
        if ({rv1, rd1} !== {1'b1, 64'h0}) begin
            errors++;
            $display("FAIL first_load got %b/%h exp 1/0", rv1, rd1);
        end
        checks++;
        apply(mk(0, 1, 0, 0, 0, 0, 0));
    endtask

    task automatic test_byte_enable();
        op_t ops[$];
        ops.push_back(mk(1, 0, 3, 64'h1122334455667788, 8'hFF, 0, 0));
        ops.push_back(mk(1, 0, 3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 0));
        ops.push_back(mk(1, 1, 3, 0, 0, 0, 0));
        ops.push_back(mk(1, 0, 3, 64'hFFFFFFFFFFFFFFFF, 8'h00, 0, 0));
        ops.push_back(mk(1, 1, 3, 0, 0, 0, 0));
        ops.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        ops.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        foreach (ops[n]) begin
            apply(ops[n]);
            step();
            if (act1() !== exp1()) begin
                errors++;
                $display("FAIL byte_enable L1 cyc=%0d got %h exp %h", cyc, act1(), exp1());
            end
            if (act2() !== exp2()) begin
                errors++;
                $display("FAIL byte_enable L2 cyc=%0d got %h exp %h", cyc, act2(), exp2());
            end
            checks += 2;
        end
        if (rd1 !== 64'h11223344AAAAAAAA || wc1 !== 32'd3 || rc1 !== 32'd3) begin
            errors++;
            $display("FAIL byte_enable_result got %h wc=%0d rc=%0d exp 11223344aaaaaaaa wc=3 rc=3",
                     rd1, wc1, rc1);
        end
        checks++;
    endtask

    task automatic test_streaming();
        op_t ops[$];
        int  pulses;
        for (int i = 0; i < 8; i++) ops.push_back(mk(1, 0, i, 64'(i * 3), 8'hFF, 0, 0));
        for (int i = 0; i < 8; i++) ops.push_back(mk(1, 1, i, 0, 0, 0, 0));
        repeat (3) ops.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        pulses = 0;
        foreach (ops[n]) begin
            apply(ops[n]);
            step();
            if (rv2) pulses++;
            if (act1() !== exp1()) begin
                errors++;
                $display("FAIL streaming L1 cyc=%0d got %h exp %h", cyc, act1(), exp1());
            end
            if (act2() !== exp2()) begin
                errors++;
                $display("FAIL streaming L2 cyc=%0d got %h exp %h", cyc, act2(), exp2());
            end
            checks += 2;
        end
        if (pulses != 16) begin
            errors++;
            $display("FAIL streaming_pulses got %0d exp 16", pulses);
        end
        checks++;
    endtask

    task automatic test_out_of_range();
        op_t ops[$];
        ops.push_back(mk(1, 1, 1024, 0, 0, 0, 0));
        ops.push_back(mk(1, 0, 32'h400, {$urandom, $urandom}, 8'hFF, 0, 0));
        ops.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        ops.push_back(mk(0, 1, 0, 0, 0, 0, 1));
        ops.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        ops.push_back(mk(1, 1, 32'h8000_0000, 0, 0, 0, 1));
        ops.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        ops.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        foreach (ops[n]) begin
            apply(ops[n]);
            step();
            if (act1() !== exp1()) begin
                errors++;
                $display("FAIL out_of_range L1 cyc=%0d got %h exp %h", cyc, act1(), exp1());
            end
            if (act2() !== exp2()) begin
                errors++;
                $display("FAIL out_of_range L2 cyc=%0d got %h exp %h", cyc, act2(), exp2());
            end
            checks += 2;
        end
        if (err1 !== 1'b1) begin
            errors++;
            $display("FAIL err_set_wins got %b exp 1", err1);
        end
        checks++;
    endtask

    task automatic test_random();
        op_t         o;
        logic [31:0] a;
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 15) == 0) ? 32'(BS + $urandom_range(0, 5000))
                                             : 32'($urandom_range(0, 15));
            o = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
                   {$urandom, $urandom}, 8'($urandom), 0, $urandom_range(0, 7) == 0);
            apply(o);
            step();
            if (act1() !== exp1()) begin
                errors++;
                $display("FAIL random L1 cyc=%0d got %h exp %h", cyc, act1(), exp1());
            end
            if (act2() !== exp2()) begin
                errors++;
                $display("FAIL random L2 cyc=%0d got %h exp %h", cyc, act2(), exp2());
            end
            checks += 2;
        end
        apply(mk(0, 1, 0, 0, 0, 0, 0));
    endtask

    task automatic test_clear(input logic [31:0] a, input bit inflight);
        op_t ops[$];
        int  grants;
        ops.push_back(mk(1, 0, a, {$urandom, $urandom} | 64'h1, 8'hFF, 0, 0));
        if (inflight) begin
            ops.push_back(mk(1, 1, a, 0, 0, 0, 0));
            ops.push_back(mk(1, 1, a, 0, 0, 1, 0));
        end else begin
            ops.push_back(mk(0, 1, 0, 0, 0, 1, 0));
        end
        for (int i = 0; i <= BS; i++) ops.push_back(mk(1, 1, a, 0, 0, 0, 0));
        repeat (3) ops.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        grants = 0;
        foreach (ops[n]) begin
            apply(ops[n]);
            #1;
            if (n >= (inflight ? 3 : 2)) grants += int'(gnt1);
            step();
            if (act1() !== exp1()) begin
                errors++;
                $display("FAIL clear L1 cyc=%0d got %h exp %h", cyc, act1(), exp1());
            end
            if (act2() !== exp2()) begin
                errors++;
                $display("FAIL clear L2 cyc=%0d got %h exp %h", cyc, act2(), exp2());
            end
            checks += 2;
        end
        if (grants != 1 || rd1 !== 64'h0) begin
            errors++;
            $display("FAIL clear_window got grants=%0d rdata=%h exp grants=1 rdata=0", grants, rd1);
        end
        checks++;
    endtask

    task automatic test_reset_midstream();
        apply(mk(1, 1, 4, 0, 0, 0, 0));
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        if (act1() !== exp1() || act2() !== exp2()) begin
            errors++;
            $display("FAIL async_reset got %h / %h exp %h / %h", act1(), act2(), exp1(), exp2());
        end
        checks++;
        for (int n = 0; n < 8; n++) begin
            if (n == 3) rst_n = 1'b1;
            step();
            if (act1() !== exp1()) begin
                errors++;
                $display("FAIL reset_midstream L1 cyc=%0d got %h exp %h", cyc, act1(), exp1());
            end
            if (act2() !== exp2()) begin
                errors++;
                $display("FAIL reset_midstream L2 cyc=%0d got %h exp %h", cyc, act2(), exp2());
            end
            checks += 2;
        end
        apply(mk(0, 1, 0, 0, 0, 0, 0));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        test_reset();
        test_byte_enable();
        test_streaming();
        test_out_of_range();
        test_random();
        test_clear(32'd9, 1'b1);
        test_clear(32'd1023, 1'b0);
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
